// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, control-bit and decode-type definitions for the MIPS core
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Bit positions inside ex_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, Link}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_JUMP     = 1;
    localparam int CTRL_LINK     = 0;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LUI  = 2'd2
    } imm_type_t;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RT   = 2'd1,
        DEST_RD   = 2'd2,
        DEST_RA   = 2'd3
    } dest_sel_t;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - opcode to main control, immediate type, destination select and rt usage
module main_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [7:0] ctrl,
    output imm_type_t  imm_type,
    output dest_sel_t  dest_sel,
    output logic       rt_src,
    output logic       illegal
);

    always_comb begin
        ctrl     = '0;
        imm_type = IMM_SEXT;
        dest_sel = DEST_NONE;
        rt_src   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                dest_sel            = DEST_RD;
                rt_src              = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                dest_sel            = DEST_RT;
            end
            OP_ANDI, OP_ORI: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_type            = IMM_ZEXT;
                dest_sel            = DEST_RT;
            end
            OP_LUI: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_type            = IMM_LUI;
                dest_sel            = DEST_RT;
            end
            OP_LW: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                dest_sel            = DEST_RT;
            end
            OP_SW: begin
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                rt_src              = 1'b1;
            end
            OP_BEQ: begin
                ctrl[CTRL_BRANCH] = 1'b1;
                rt_src            = 1'b1;
            end
            OP_J: begin
                ctrl[CTRL_JUMP] = 1'b1;
            end
            OP_JAL: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
                ctrl[CTRL_LINK]     = 1'b1;
                dest_sel            = DEST_RA;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode, writeback bypass, load-use detection and the ID/EX register
module id_ex_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  JAL_REG  = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  RA1,
    output logic [4:0]  RA2,
    input  logic [31:0] DR1,
    input  logic [31:0] DR2,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_AW,
    input  logic [31:0] wb_WriteData,
    output logic        hazard_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic [4:0]  ex_shamt,
    output logic [5:0]  ex_funct,
    output logic [7:0]  ex_ctrl,
    output logic        ex_illegal
);

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign shamt  = in_instr[10:6];
    assign funct  = in_instr[5:0];
    assign imm16  = in_instr[15:0];

    assign RA1 = rs;
    assign RA2 = rt;

    logic [7:0] dec_ctrl;
    imm_type_t  dec_imm_type;
    dest_sel_t  dec_dest_sel;
    logic       dec_rt_src;
    logic       dec_illegal;

    main_decoder u_main_decoder (
        .opcode   (opcode),
        .ctrl     (dec_ctrl),
        .imm_type (dec_imm_type),
        .dest_sel (dec_dest_sel),
        .rt_src   (dec_rt_src),
        .illegal  (dec_illegal)
    );

    logic [31:0] imm_ext;
    logic [4:0]  dest;
    logic [7:0]  ctrl;

    always_comb begin
        imm_ext = {{16{imm16[15]}}, imm16};
        case (dec_imm_type)
            IMM_ZEXT: imm_ext = {16'h0000, imm16};
            IMM_LUI:  imm_ext = {imm16, 16'h0000};
            default:  imm_ext = {{16{imm16[15]}}, imm16};
        endcase
    end

    always_comb begin
        dest = 5'd0;
        case (dec_dest_sel)
            DEST_RT:  dest = rt;
            DEST_RD:  dest = rd;
            DEST_RA:  dest = JAL_REG;
            default:  dest = 5'd0;
        endcase
    end

    // Writes to $zero are architecturally discarded, so never advertise them downstream.
    always_comb begin
        ctrl = dec_ctrl;
        if (dest == 5'd0) ctrl[CTRL_REGWRITE] = 1'b0;
    end

    function automatic logic [31:0] sel_operand(
        input logic [4:0]  field,
        input logic [31:0] rf_data,
        input logic        wb_we,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data
    );
        if (field == 5'd0)                    return 32'h0;
        else if (wb_we && (wb_addr == field)) return wb_data;
        else                                  return rf_data;
    endfunction

    logic [31:0] rs_data, rt_data;

    assign rs_data = sel_operand(rs, DR1, wb_RegWrite, wb_AW, wb_WriteData);
    assign rt_data = sel_operand(rt, DR2, wb_RegWrite, wb_AW, wb_WriteData);

    assign hazard_stall = ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_dest != 5'd0) && in_valid &&
                          ((ex_dest == rs) || ((ex_dest == rt) && dec_rt_src));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || (!stall && hazard_stall)) begin
            ex_valid   <= 1'b0;
            ex_pc      <= RESET_PC;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dest    <= '0;
            ex_shamt   <= '0;
            ex_funct   <= '0;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
        end else if (!stall) begin
            ex_valid   <= in_valid;
            ex_pc      <= in_pc;
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_imm     <= imm_ext;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_dest    <= dest;
            ex_shamt   <= shamt;
            ex_funct   <= funct;
            ex_ctrl    <= in_valid ? ctrl : 8'h00;
            ex_illegal <= in_valid && dec_illegal;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode stage plus ID/EX pipeline register of the pipelined MIPS core. It sits directly upstream of the register file: it drives the register-file read addresses from the incoming instruction and captures the two read values. It also decodes main control and selects the immediate and destination register. It detects load-use hazards and bypasses same-cycle writeback data, then presents a registered bundle to the EX stage.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into ex_pc on reset or bubble.
- JAL_REG, 5'd31, destination register for jal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds a real instruction
- in_pc  in  32  PC+4 of the IF/ID instruction
- in_instr  in  32  IF/ID instruction word
- stall  in  1  downstream hold; registers keep their value
- flush  in  1  branch/jump squash; load a bubble
- RA1  out  5  in_instr[25:21], combinational, to the register file
- RA2  out  5  in_instr[20:16], combinational, to the register file
- DR1  in  32  register-file read data 1
- DR2  in  32  register-file read data 2
- wb_RegWrite  in  1  writeback write enable (same signal that feeds the register file)
- wb_AW  in  5  writeback address
- wb_WriteData  in  32  writeback data
- hazard_stall  out  1  combinational; IF/ID and PC must hold this cycle
- ex_valid  out  1  registered valid
- ex_pc  out  32  registered PC+4
- ex_rs_data  out  32  registered operand A
- ex_rt_data  out  32  registered operand B
- ex_imm  out  32  registered extended immediate
- ex_rs  out  5  registered rs field
- ex_rt  out  5  registered rt field
- ex_dest  out  5  registered destination register
- ex_shamt  out  5  registered shamt field
- ex_funct  out  6  registered funct field
- ex_ctrl  out  8  registered control bits {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, Link}
- ex_illegal  out  1  registered flag: valid instruction with an unsupported opcode

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs are 0, except ex_pc, which is RESET_PC.
- Decode is combinational from in_instr. Supported opcodes and their controls:
  - 0x00 R-type: RegWrite; dest=rd.
  - 0x08 addi, 0x0A slti: RegWrite, ALUSrc; immediate sign-extended; dest=rt.
  - 0x0C andi, 0x0D ori: RegWrite, ALUSrc; immediate zero-extended; dest=rt.
  - 0x0F lui: RegWrite, ALUSrc; imm = {instr[15:0],16'h0}; dest=rt.
  - 0x23 lw: RegWrite, MemRead, MemtoReg, ALUSrc; immediate sign-extended; dest=rt.
  - 0x2B sw: MemWrite, ALUSrc; immediate sign-extended.
  - 0x04 beq: Branch; immediate sign-extended.
  - 0x02 j: Jump.
  - 0x03 jal: Jump, Link, RegWrite; dest=JAL_REG.
  - Any other opcode: ctrl=0 and illegal=1.
- Destination 0: RegWrite is forced to 0.
- Operand select for A (and identically for B using rt/DR2):
  - If the field is 0, the operand is 0.
  - Otherwise, if wb_RegWrite is high and wb_AW equals the field, the operand is wb_WriteData (bypass).
  - Otherwise, the operand is DR1.
- Load-use hazard: hazard_stall = ex_valid & ex_ctrl.MemRead & ex_dest!=0 & in_valid & (ex_dest==rs | (ex_dest==rt & opcode uses rt as source)).
  - rt is a source only for R-type, sw and beq.
- Register update on each clk edge, first matching rule wins:
  1. flush: load a bubble.
  2. stall: hold all registers.
  3. hazard_stall: load a bubble; IF/ID keeps the instruction, so it re-decodes next cycle.
  4. otherwise: load the decoded bundle; ex_valid=in_valid.
- Bubble: ex_valid=0, ex_ctrl=0, ex_illegal=0, ex_dest=0. Data fields are don't-care; the implementation clears them to 0.
- in_valid=0: ex_ctrl and ex_illegal are loaded as 0.
- Latency: 1 cycle from IF/ID to EX.
- hazard_stall is asserted for exactly one cycle per load-use pair, because the bubble clears ex_MemRead.
- flush and stall asserted together: flush wins.
- Reset deasserting mid-operation: the first edge after release loads normally.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, ...);
  - control-bit index constants for ex_ctrl;
  - the immediate-type encoding (SEXT, ZEXT, LUI).
- One combinational sub-module, main_decoder (opcode -> ctrl, imm type, dest select, rt-is-source, illegal). Instantiated once.
- Bypass, hazard logic and pipeline registers live in id_ex_stage.

Test Plan:
- Reset, then release: all ex_* outputs are 0 and ex_pc=RESET_PC. Apply addi $t0,$zero,-5 (0x2008FFFB) with in_valid=1 -> next cycle ex_imm=32'hFFFFFFFB, ex_dest=8, ex_ctrl=RegWrite|ALUSrc.
- ori $t1,$t1,0x8000 -> ex_imm=32'h00008000. lui $t2,0x1234 -> ex_imm=32'h12340000. jal -> ex_dest=31. Opcode 0x3F -> ex_illegal=1, ex_ctrl=0.
- Bypass: DR1=32'h1111, with wb_RegWrite=1, wb_AW=rs=9, wb_WriteData=32'hABCD -> ex_rs_data=32'hABCD. Same case with rs=0 -> ex_rs_data=0.
- Load-use: cycle n loads lw $t0,0($s0). Cycle n+1 presents add $t1,$t0,$t2 -> hazard_stall=1 and a bubble enters. Cycle n+2: hazard_stall=0 and the add is captured with ex_valid=1.
- Load-use negative case: lw $t0 followed by sw $t0,0($s1) using rt as the store data -> hazard_stall=1. lw $t0 followed by addi $t3,$s1,4 -> hazard_stall=0.
- Control priority: stall=1 for 3 cycles -> ex_* outputs are unchanged. flush=1 together with stall=1 -> ex_valid=0, ex_ctrl=0. Assert rst_n=0 mid-cycle -> outputs clear immediately, without waiting for a clock edge.
